// File: rtl/udp_cmd_ctrl_if.sv
// Command bus between register write port, queue and UDP engine.
// Write side carries control words; command side is a valid/ready handshake.
interface udp_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int HOST_W     = 4,
    parameter int DST_W      = 4,
    parameter int PKT_W      = 4
);
    logic [DATA_WIDTH-1:0] data;
    logic                  wren;
    logic                  cmd_ready;
    logic                  cmd_valid;
    logic [HOST_W-1:0]     host;
    logic [DST_W-1:0]      dst;
    logic [PKT_W-1:0]      packet;
    logic                  start_udp_o;

    modport master (
        output data, wren, cmd_ready,
        input  cmd_valid, host, dst, packet, start_udp_o
    );

    modport slave (
        input  data, wren, cmd_ready,
        output cmd_valid, host, dst, packet, start_udp_o
    );
endinterface

// File: rtl/udp_cmd_ctrl.sv
// Queued UDP command decoder with show-ahead head and start pulse.
// UDP_CMD_STATUS_EN adds status_o (occupancy + saturating drop count).
module udp_cmd_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int HOST_W     = 4,
    parameter int DST_W      = 4,
    parameter int PKT_W      = 4,
    parameter int DEPTH      = 4
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clr_ovf,
    udp_cmd_ctrl_if.slave bus,
    output logic full_o,
`ifdef UDP_CMD_STATUS_EN
    output logic overflow_o,
    output logic [15:0] status_o
`else
    output logic overflow_o
`endif
);
    localparam int EW = HOST_W + DST_W + PKT_W;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (1 + EW > DATA_WIDTH) begin : g_bad_width
        $error("udp_cmd_ctrl: fields exceed DATA_WIDTH");
    end
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("udp_cmd_ctrl: DEPTH must be a power of two >= 2");
    end
    if (DATA_WIDTH > EW + 1) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^bus.data[DATA_WIDTH-1:EW+1];
    end

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          push_req, push, pop, drop;
    logic [EW-1:0] head;

    always_comb begin
        push_req = bus.wren & bus.data[0];
        pop      = valid_q & bus.cmd_ready;
        // A full queue still accepts when the head leaves this cycle.
        push     = push_req & (~full_q | pop);
        drop     = push_req & full_q & ~pop;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = bus.data[EW:1];
        end
        wr_d    = wr_q + PW'(push);
        rd_d    = rd_q + PW'(pop);
        valid_d = wr_d != rd_d;
        full_d  = (wr_d - rd_d) == PW'(DEPTH);
        ovf_d   = drop | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    assign head            = mem_q[rd_q[AW-1:0]];
    assign bus.host        = head[HOST_W-1:0];
    assign bus.dst         = head[HOST_W+DST_W-1:HOST_W];
    assign bus.packet      = head[EW-1:HOST_W+DST_W];
    assign bus.cmd_valid   = valid_q;
    assign bus.start_udp_o = pop;
    assign full_o          = full_q;
    assign overflow_o      = ovf_q;

`ifdef UDP_CMD_STATUS_EN
    logic [7:0]    drops_q, drops_d;
    logic [PW-1:0] occ;

    always_comb begin
        drops_d = drops_q;
        if (drop && drops_q != 8'hFF) begin
            drops_d = drops_q + 8'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            drops_q <= '0;
        end else begin
            drops_q <= drops_d;
        end
    end

    assign occ      = wr_q - rd_q;
    assign status_o = {drops_q, 8'(occ)};
`endif
endmodule

// File: tb/tb_udp_cmd_ctrl.sv
// Self-checking bench: queue-based reference model plus directed vectors.
// Build with or without UDP_CMD_STATUS_EN.
module tb_udp_cmd_ctrl;
    localparam int DEPTH = 4;

    logic aclk;
    logic aresetn;
    logic clr_ovf;
    logic full_o;
    logic overflow_o;
`ifdef UDP_CMD_STATUS_EN
    logic [15:0] status_o;
`endif

    udp_cmd_ctrl_if #(
        .DATA_WIDTH(32), .HOST_W(4), .DST_W(4), .PKT_W(4)
    ) bus ();

    udp_cmd_ctrl #(
        .DATA_WIDTH(32), .HOST_W(4), .DST_W(4),
        .PKT_W(4), .DEPTH(DEPTH)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .clr_ovf(clr_ovf),
        .bus(bus.slave),
        .full_o(full_o),
`ifdef UDP_CMD_STATUS_EN
        .overflow_o(overflow_o),
        .status_o(status_o)
`else
        .overflow_o(overflow_o)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h",
                      name, act, exp);
    endtask

    // Reference model: a queue of {packet,dst,host} entries.
    logic [11:0] m_q[$];
    logic        m_ovf;
    int          m_drops;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            bit preq, pop;
            preq = bus.wren && bus.data[0];
            pop  = (m_q.size() != 0) && bus.cmd_ready;
            if (preq && m_q.size() == DEPTH && !pop) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end else begin
                if (clr_ovf) m_ovf = 1'b0;
                if (pop) void'(m_q.pop_front());
                if (preq) m_q.push_back(bus.data[12:1]);
            end
        end
    end

    always @(negedge aclk) begin
        if (!aresetn) begin
            chk("rst_valid", 32'(bus.cmd_valid), 0);
            chk("rst_start", 32'(bus.start_udp_o), 0);
            chk("rst_full", 32'(full_o), 0);
            chk("rst_ovf", 32'(overflow_o), 0);
            chk("rst_head",
                {20'b0, bus.packet, bus.dst, bus.host}, 0);
        end else begin
            bit mv;
            mv = m_q.size() != 0;
            chk("cmd_valid", 32'(bus.cmd_valid), 32'(mv));
            chk("start_udp", 32'(bus.start_udp_o),
                32'(mv && bus.cmd_ready));
            chk("full", 32'(full_o), 32'(m_q.size() == DEPTH));
            chk("overflow", 32'(overflow_o), 32'(m_ovf));
            if (mv) begin
                chk("head", {20'b0, bus.packet, bus.dst, bus.host},
                    {20'b0, m_q[0]});
            end else begin
                chk("head_x", 32'($isunknown(
                    {bus.packet, bus.dst, bus.host})), 0);
            end
`ifdef UDP_CMD_STATUS_EN
            chk("status", {16'b0, status_o},
                {16'b0, 8'(m_drops), 8'(m_q.size())});
`endif
        end
    end

    function automatic logic [31:0] mk(int h, int d, int p);
        return {19'b0, 4'(p), 4'(d), 4'(h), 1'b1};
    endfunction

    task automatic drive(logic w, logic [31:0] d, logic r,
                         logic c);
        bus.wren      = w;
        bus.data      = d;
        bus.cmd_ready = r;
        clr_ovf       = c;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic cyc(logic w, logic [31:0] d, logic r,
                       logic c);
        drive(w, d, r, c);
        tick();
        drive(0, 32'h0, 0, 0);
    endtask

    initial begin
        aresetn = 1'b0;
        drive(0, 32'h0, 0, 0);
        tick();
        tick();
        aresetn = 1'b1;

        // Single command: field decode and one start pulse
        cyc(1, 32'h0000_0B53, 0, 0);
        chk("lit_valid", 32'(bus.cmd_valid), 1);
        chk("lit_host", 32'(bus.host), 9);
        chk("lit_dst", 32'(bus.dst), 10);
        chk("lit_pkt", 32'(bus.packet), 5);
        drive(0, 32'h0, 1, 0);
        #1;
        chk("lit_start", 32'(bus.start_udp_o), 1);
        tick();
        drive(0, 32'h0, 0, 0);
        chk("lit_popped", 32'(bus.cmd_valid), 0);
        chk("lit_nostart", 32'(bus.start_udp_o), 0);

        // start bit clear: ignored
        cyc(1, 32'h0000_0B52, 0, 0);
        chk("lit_ignored", 32'(bus.cmd_valid), 0);

        // Fill, overflow, drain in order
        for (int i = 0; i < 4; i++)
            cyc(1, mk(3 * i + 1, 3 * i + 2, 3 * i + 3), 0, 0);
        chk("lit_full", 32'(full_o), 1);
        chk("lit_noovf", 32'(overflow_o), 0);
        cyc(1, mk(13, 14, 15), 0, 0);
        chk("lit_ovf", 32'(overflow_o), 1);
        chk("lit_full2", 32'(full_o), 1);
`ifdef UDP_CMD_STATUS_EN
        chk("lit_drops1", 32'(status_o[15:8]), 1);
        chk("lit_occ4", 32'(status_o[7:0]), 4);
`endif
        for (int i = 0; i < 4; i++) begin
            chk("lit_drain_h", 32'(bus.host), 32'(3 * i + 1));
            chk("lit_drain_p", 32'(bus.packet), 32'(3 * i + 3));
            cyc(0, 32'h0, 1, 0);
        end
        chk("lit_empty", 32'(bus.cmd_valid), 0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) cyc(1, mk(i, 0, i), 0, 0);
        cyc(1, mk(5, 6, 7), 1, 0);
        chk("lit_full_pp", 32'(full_o), 1);
        for (int i = 2; i <= 5; i++) begin
            chk("lit_pp_h", 32'(bus.host), 32'(i));
            cyc(0, 32'h0, 1, 0);
        end
        chk("lit_pp_empty", 32'(bus.cmd_valid), 0);

        // Overflow clear: set-dominant against a drop
        cyc(0, 32'h0, 0, 1);
        chk("lit_clr", 32'(overflow_o), 0);
        for (int i = 6; i <= 9; i++) cyc(1, mk(i, 1, 2), 0, 0);
        cyc(1, mk(15, 1, 1), 0, 1);
        chk("lit_setdom", 32'(overflow_o), 1);
`ifdef UDP_CMD_STATUS_EN
        chk("lit_drops2", 32'(status_o[15:8]), 2);
`endif
        cyc(0, 32'h0, 0, 1);
        chk("lit_clr2", 32'(overflow_o), 0);
`ifdef UDP_CMD_STATUS_EN
        chk("lit_drops_kept", 32'(status_o[15:8]), 2);
`endif

        // Reset mid-handshake with 3 entries queued
        cyc(0, 32'h0, 1, 0);
        drive(0, 32'h0, 1, 0);
        #2;
        aresetn = 1'b0;
        #1;
        chk("lit_rst_valid", 32'(bus.cmd_valid), 0);
        chk("lit_rst_start", 32'(bus.start_udp_o), 0);
        chk("lit_rst_full", 32'(full_o), 0);
        chk("lit_rst_head",
            {20'b0, bus.packet, bus.dst, bus.host}, 0);
`ifdef UDP_CMD_STATUS_EN
        chk("lit_rst_status", {16'b0, status_o}, 0);
`endif
        tick();
        aresetn = 1'b1;
        tick();
        tick();
        chk("lit_post_rst", 32'(bus.cmd_valid), 0);
        cyc(1, mk(3, 3, 3), 0, 0);
        chk("lit_repush", 32'(bus.cmd_valid), 1);
        chk("lit_repush_h", 32'(bus.host), 3);
        cyc(0, 32'h0, 1, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
